// File: rtl/bet_reader.sv
// Ticket-scanner front end: validates the four bet numbers, registers them for the
// checker and emits a settled scan strobe, with timeout abort and bet statistics.
module bet_reader #(
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       num_valid,
    input  logic [4:0] num_in,
    output logic       num_ready,
    output logic [4:0] B1,
    output logic [4:0] B2,
    output logic [4:0] B3,
    output logic [4:0] B4,
    output logic [1:0] number,
    output logic       RD_ERR,
    output logic       scan,
    output logic       bet_done,
    output logic       bet_abort,
    output logic [7:0] bet_count,
    output logic [7:0] error_count
);
    typedef enum logic [1:0] {INIT, READY, SETUP, STROBE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state, w_next;
    logic [1:0]      r_idx;
    logic [TO_W-1:0] r_to;
    logic [3:0][4:0] r_b;
    logic [1:0]      r_number;
    logic            r_err, r_abort;
    logic [7:0]      r_bc, r_ec;
    logic            w_xfer, w_expire, w_dup, w_invalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:    w_next = READY;
            READY:   if (w_xfer) w_next = SETUP;
            SETUP:   w_next = STROBE;
            STROBE:  w_next = READY;
            default: w_next = INIT;
        endcase
    end

    always_comb begin
        num_ready = (r_state == READY);
        scan      = (r_state == STROBE);
        bet_done  = (r_state == STROBE) && (r_idx == 2'd3);
    end

    assign w_xfer = num_valid && num_ready;

    // Only slots already written in this bet (below the current index) count as duplicates.
    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < 3; k++)
            if (2'(k) < r_idx && r_b[k] == num_in) w_dup = 1'b1;
    end

    assign w_invalid = (num_in == 5'd0) || w_dup;
    assign w_expire  = (r_state == READY) && (r_idx != 2'd0) && !w_xfer && (r_to == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_to     <= '0;
            r_b      <= '0;
            r_number <= '0;
            r_err    <= 1'b0;
            r_abort  <= 1'b0;
            r_bc     <= '0;
            r_ec     <= '0;
        end else begin
            r_abort <= 1'b0;
            if (w_xfer) begin
                r_b[r_idx] <= num_in;
                r_number   <= r_idx;
                r_err      <= (r_idx == 2'd0) ? w_invalid : (r_err | w_invalid);
                r_to       <= '0;
            end else if (w_expire) begin
                r_abort <= 1'b1;
                r_err   <= 1'b1;
                r_idx   <= '0;
                r_to    <= '0;
                if (r_ec != 8'hFF) r_ec <= r_ec + 8'd1;
            end else if (r_state == READY && r_idx != 2'd0) begin
                r_to <= r_to + 1'b1;
            end
            if (r_state == STROBE) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    if (r_err) begin
                        if (r_ec != 8'hFF) r_ec <= r_ec + 8'd1;
                    end else begin
                        if (r_bc != 8'hFF) r_bc <= r_bc + 8'd1;
                    end
                end
            end
        end
    end

    assign B1          = r_b[0];
    assign B2          = r_b[1];
    assign B3          = r_b[2];
    assign B4          = r_b[3];
    assign number      = r_number;
    assign RD_ERR      = r_err;
    assign bet_abort   = r_abort;
    assign bet_count   = r_bc;
    assign error_count = r_ec;
endmodule

// File: tb/tb_bet_reader.sv
// Bench for bet_reader: bet-level reference model checked every cycle, a table of
// directed bets, hand-written timeout/reset sequences and randomized traffic.
module tb_bet_reader;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset, num_valid;
    logic [4:0] num_in;
    logic       num_ready, RD_ERR, scan, bet_done, bet_abort;
    logic [4:0] B1, B2, B3, B4;
    logic [1:0] number;
    logic [7:0] bet_count, error_count;

    bet_reader #(.TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .reset(reset), .num_valid(num_valid), .num_in(num_in),
        .num_ready(num_ready), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .number(number), .RD_ERR(RD_ERR), .scan(scan), .bet_done(bet_done),
        .bet_abort(bet_abort), .bet_count(bet_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_scan = 0, n_done = 0;

    // Reference model: the bet is a list of accepted numbers; m_wait counts the
    // non-ready cycles left after an accept (2 = settling, 1 = strobing).
    bit m_init, m_abort, m_err, m_xfer;
    int m_wait, m_idle, m_number, m_bc, m_ec;
    int m_b[4];
    int m_list[$];

    typedef struct packed {
        logic [3:0][4:0] n;
        logic [3:0]      err;
        logic [7:0]      bc;
        logic [7:0]      ec;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 1; m_abort = 0; m_err = 0; m_xfer = 0;
        m_wait = 0; m_idle = 0; m_number = 0; m_bc = 0; m_ec = 0;
        for (int i = 0; i < 4; i++) m_b[i] = 0;
        m_list.delete();
    endtask

    task automatic model_step(input bit v, input int n);
        bit bad;
        m_abort = 0;
        m_xfer  = 0;
        if (m_init) m_init = 0;
        else if (m_wait == 2) m_wait = 1;
        else if (m_wait == 1) begin
            m_wait = 0;
            if (m_list.size() == 4) begin
                if (m_err) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                else       m_bc = (m_bc < 255) ? m_bc + 1 : 255;
                m_list.delete();
            end
        end else if (v) begin
            bad = (n == 0);
            foreach (m_list[i]) if (m_list[i] == n) bad = 1;
            m_err = (m_list.size() == 0) ? bad : (m_err | bad);
            m_b[m_list.size()] = n;
            m_number = m_list.size();
            m_list.push_back(n);
            m_wait = 2; m_idle = 0; m_xfer = 1;
        end else if (m_list.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_abort = 1; m_err = 1; m_idle = 0;
                m_list.delete();
                m_ec = (m_ec < 255) ? m_ec + 1 : 255;
            end
        end
    endtask

    task automatic check_all();
        chk("num_ready", num_ready, int'(!m_init && m_wait == 0));
        chk("scan", scan, int'(m_wait == 1));
        chk("bet_done", bet_done, int'(m_wait == 1 && m_list.size() == 4));
        chk("bet_abort", bet_abort, int'(m_abort));
        chk("B1", B1, m_b[0]);
        chk("B2", B2, m_b[1]);
        chk("B3", B3, m_b[2]);
        chk("B4", B4, m_b[3]);
        chk("number", number, m_number);
        chk("RD_ERR", RD_ERR, int'(m_err));
        chk("bet_count", bet_count, m_bc);
        chk("error_count", error_count, m_ec);
    endtask

    task automatic tick(input bit v, input int n);
        num_valid = v;
        num_in    = 5'(n);
        @(posedge clk);
        model_step(v, n);
        @(negedge clk);
        if (scan) n_scan++;
        if (bet_done) n_done++;
        check_all();
    endtask

    task automatic send(input int n);
        for (int i = 0; i < 20; i++) begin
            tick(1, n);
            if (m_xfer) break;
        end
        if (!m_xfer) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: number %0d not accepted within 20 cycles", n);
        end
    endtask

    task automatic run_bet(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
        tick(0, 0); tick(0, 0);
    endtask

    initial begin
        int s0, d0, cnt;
        tbl[0] = '{n: {5'd25, 5'd12, 5'd7, 5'd3}, err: 4'b0000, bc: 8'd1, ec: 8'd0};
        tbl[1] = '{n: {5'd20, 5'd5,  5'd9, 5'd5}, err: 4'b1100, bc: 8'd1, ec: 8'd1};
        tbl[2] = '{n: {5'd4,  5'd3,  5'd2, 5'd1}, err: 4'b0000, bc: 8'd2, ec: 8'd1};
        tbl[3] = '{n: {5'd16, 5'd8,  5'd4, 5'd0}, err: 4'b1111, bc: 8'd2, ec: 8'd2};

        reset = 1; num_valid = 0; num_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 0;
        tick(0, 0);
        chk("ready_after_release", num_ready, 1);

        // Table of directed bets, num_valid held high throughout each bet
        foreach (tbl[t]) begin
            s0 = n_scan; d0 = n_done;
            for (int k = 0; k < 4; k++) begin
                send(int'(tbl[t].n[k]));
                chk("tbl_number", number, k);
                chk("tbl_rderr", RD_ERR, int'(tbl[t].err[k]));
            end
            tick(0, 0); tick(0, 0);
            chk("tbl_scans", n_scan - s0, 4);
            chk("tbl_done", n_done - d0, 1);
            chk("tbl_bet_count", bet_count, int'(tbl[t].bc));
            chk("tbl_error_count", error_count, int'(tbl[t].ec));
        end

        // Timeout: two numbers then silence
        send(10); send(11);
        s0 = n_scan; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0); cnt++;
            if (bet_abort) break;
        end
        chk("abort_latency", cnt, 10);
        chk("abort_rderr", RD_ERR, 1);
        chk("abort_scans", n_scan - s0, 1);
        chk("abort_error_count", error_count, 3);
        send(13);
        chk("number_after_abort", number, 0);
        chk("rderr_after_abort", RD_ERR, 0);
        tick(0, 0); tick(0, 0);

        // Transfer lands on the expiry cycle: transfer wins
        send(14);
        tick(0, 0); tick(0, 0);
        repeat (7) tick(0, 0);
        tick(1, 15);
        chk("expiry_xfer_number", number, 2);
        chk("expiry_no_abort", bet_abort, 0);
        tick(0, 0); tick(0, 0);
        send(16);
        tick(0, 0); tick(0, 0);
        chk("expiry_bet_count", bet_count, 3);

        // Reset while index 1 is in SETUP
        send(20); tick(0, 0); tick(0, 0); send(21);
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 0;
        tick(0, 0);
        chk("ready_after_midreset", num_ready, 1);
        send(22);
        chk("number_after_midreset", number, 0);
        tick(0, 0); tick(0, 0);

        // Randomized traffic with varying density so timeouts and duplicates occur
        for (int seg = 0; seg < 12; seg++) begin
            int p;
            p = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 40 : 3);
            for (int i = 0; i < 60; i++)
                tick($urandom_range(0, 99) < p,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
        end

        // Counter saturation
        reset = 1; #1; model_reset(); @(negedge clk); reset = 0; tick(0, 0);
        for (int i = 0; i < 258; i++) run_bet(1, 2, 3, 4);
        chk("bet_count_sat", bet_count, 255);
        for (int i = 0; i < 258; i++) run_bet(0, 2, 3, 4);
        chk("error_count_sat", error_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
